// File: rtl/alu_design.sv
// Multi-function registered ALU: adder with carry, full 16x16 multiplier,
// add/subtract unit with carry/no-borrow flag, and an unsigned comparator.
// Each cycle, sel chooses which function's result registers update.
// Results appear one cycle after their operands are sampled.
module alu_design (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Op,
  input  logic [15:0] j,
  input  logic [15:0] k,
  output logic [15:0] y1,
  output logic [31:0] y2,
  output logic [15:0] y3,
  output logic        cout,
  output logic        carry_out,
  output logic        m
);

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_MUL    = 2'b01,
    OP_ADDSUB = 2'b10,
    OP_CMP    = 2'b11
  } opSel_e;

  opSel_e      opSel;

  logic [16:0] addSumWide;
  logic [31:0] mulProduct;
  logic [15:0] asOperandB;
  logic [16:0] asResultWide;
  logic        cmpGreater;

  logic [15:0] addSum_q,    addSum_d;
  logic        addCarry_q,  addCarry_d;
  logic [31:0] mulProd_q,   mulProd_d;
  logic [15:0] asResult_q,  asResult_d;
  logic        asCarry_q,   asCarry_d;
  logic        cmpResult_q, cmpResult_d;

  assign opSel = opSel_e'(sel);

  // Datapath for every function is computed in parallel each cycle; the
  // subtract path inverts B and injects a carry of 1, so its carry-out
  // reads directly as "no borrow" (A >= B).
  always_comb begin
    addSumWide   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    mulProduct   = {16'b0, x} * {16'b0, y};
    asOperandB   = Op ? ~B : B;
    asResultWide = {1'b0, A} + {1'b0, asOperandB} + {16'b0, Op};
    cmpGreater   = (j > k);
  end

  // Next-state selection: only the selected function's registers take a
  // new value; everything else holds so earlier results stay visible.
  always_comb begin
    addSum_d    = addSum_q;
    addCarry_d  = addCarry_q;
    mulProd_d   = mulProd_q;
    asResult_d  = asResult_q;
    asCarry_d   = asCarry_q;
    cmpResult_d = cmpResult_q;
    unique case (opSel)
      OP_ADD: begin
        addSum_d   = addSumWide[15:0];
        addCarry_d = addSumWide[16];
      end
      OP_MUL: begin
        mulProd_d = mulProduct;
      end
      OP_ADDSUB: begin
        asResult_d = asResultWide[15:0];
        asCarry_d  = asResultWide[16];
      end
      OP_CMP: begin
        cmpResult_d = cmpGreater;
      end
      default: begin
      end
    endcase
  end

  // Result registers; reset clears every result and overrides any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      addSum_q    <= 16'd0;
      addCarry_q  <= 1'b0;
      mulProd_q   <= 32'd0;
      asResult_q  <= 16'd0;
      asCarry_q   <= 1'b0;
      cmpResult_q <= 1'b0;
    end else begin
      addSum_q    <= addSum_d;
      addCarry_q  <= addCarry_d;
      mulProd_q   <= mulProd_d;
      asResult_q  <= asResult_d;
      asCarry_q   <= asCarry_d;
      cmpResult_q <= cmpResult_d;
    end
  end

  assign y1        = addSum_q;
  assign cout      = addCarry_q;
  assign y2        = mulProd_q;
  assign y3        = asResult_q;
  assign carry_out = asCarry_q;
  assign m         = cmpResult_q;

endmodule

// File: tb/tb_alu_design.sv
// Directed testbench for alu_design: hand-computed vectors for each
// function, hold behaviour of unselected results, and reset priority.
module tb_alu_design;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] x, y;
  logic [15:0] A, B;
  logic        Op;
  logic [15:0] j, k;
  logic [15:0] y1;
  logic [31:0] y2;
  logic [15:0] y3;
  logic        cout;
  logic        carry_out;
  logic        m;

  int vectors     = 0;
  int miscompares = 0;

  alu_design dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .x         (x),
    .y         (y),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .j         (j),
    .k         (k),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .cout      (cout),
    .carry_out (carry_out),
    .m         (m)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Let one rising edge sample the currently driven inputs, then settle
  // 1 unit past the edge so outputs are read away from it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag,
                          input logic [15:0] eY1, input logic eCout,
                          input logic [31:0] eY2,
                          input logic [15:0] eY3, input logic eCarry,
                          input logic eM);
    checkOutput({tag, ".y1"},        {16'd0, y1},        {16'd0, eY1});
    checkOutput({tag, ".cout"},      {31'd0, cout},      {31'd0, eCout});
    checkOutput({tag, ".y2"},        y2,                 eY2);
    checkOutput({tag, ".y3"},        {16'd0, y3},        {16'd0, eY3});
    checkOutput({tag, ".carry_out"}, {31'd0, carry_out}, {31'd0, eCarry});
    checkOutput({tag, ".m"},         {31'd0, m},         {31'd0, eM});
  endtask

  initial begin
    // Reset with an active add and nonzero operands: reset must win.
    rst = 1'b1; sel = 2'b00;
    a = 16'd5; b = 16'd7; cin = 1'b1;
    x = 16'd3; y = 16'd4; A = 16'd9; B = 16'd1; Op = 1'b0;
    j = 16'd8; k = 16'd1;
    applyStimulus();
    applyStimulus();
    checkAll("reset", 16'd0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0);

    // Adder, unused operands set to junk that must not leak anywhere.
    rst = 1'b0;
    sel = 2'b00; a = 16'd10; b = 16'd20; cin = 1'b0;
    x = 16'h1234; y = 16'h00FF; A = 16'hAAAA; B = 16'h5555; Op = 1'b1;
    j = 16'hFFFF; k = 16'd0;
    applyStimulus();
    checkAll("add10+20", 16'd30, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0);

    sel = 2'b00; a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
    applyStimulus();
    checkAll("addOverflow", 16'h0001, 1'b1, 32'd0, 16'd0, 1'b0, 1'b0);

    sel = 2'b00; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    applyStimulus();
    checkOutput("addMax.y1",   {16'd0, y1},   32'h0000FFFF);
    checkOutput("addMax.cout", {31'd0, cout}, 32'd1);

    // Multiplier; cin flipped to show it is ignored outside the adder.
    sel = 2'b01; x = 16'd25; y = 16'd11; cin = 1'b0; a = 16'd0; b = 16'd0;
    applyStimulus();
    checkAll("mul25x11", 16'hFFFF, 1'b1, 32'h00000113, 16'd0, 1'b0, 1'b0);

    sel = 2'b01; x = 16'hFFFF; y = 16'hFFFF;
    applyStimulus();
    checkOutput("mulMax.y2", y2, 32'hFFFE0001);

    // Add/subtract unit.
    sel = 2'b10; A = 16'd12; B = 16'd12; Op = 1'b1;
    applyStimulus();
    checkAll("sub12-12", 16'hFFFF, 1'b1, 32'hFFFE0001, 16'd0, 1'b1, 1'b0);

    sel = 2'b10; A = 16'd5; B = 16'd12; Op = 1'b1;
    applyStimulus();
    checkOutput("sub5-12.y3",        {16'd0, y3},        32'h0000FFF9);
    checkOutput("sub5-12.carry_out", {31'd0, carry_out}, 32'd0);

    sel = 2'b10; A = 16'd12; B = 16'd12; Op = 1'b0;
    applyStimulus();
    checkOutput("add12+12.y3",        {16'd0, y3},        32'd24);
    checkOutput("add12+12.carry_out", {31'd0, carry_out}, 32'd0);

    sel = 2'b10; A = 16'hFFFF; B = 16'h0001; Op = 1'b0;
    applyStimulus();
    checkOutput("asAddWrap.y3",        {16'd0, y3},        32'd0);
    checkOutput("asAddWrap.carry_out", {31'd0, carry_out}, 32'd1);

    // Comparator; Op toggled to show it is ignored outside add/subtract.
    sel = 2'b11; j = 16'hFF12; k = 16'd3; Op = 1'b1;
    applyStimulus();
    checkAll("cmpGt", 16'hFFFF, 1'b1, 32'hFFFE0001, 16'd0, 1'b1, 1'b1);

    sel = 2'b11; j = 16'd3; k = 16'd3;
    applyStimulus();
    checkOutput("cmpEq.m", {31'd0, m}, 32'd0);

    sel = 2'b11; j = 16'd4; k = 16'd3;
    applyStimulus();
    checkOutput("cmp4gt3.m", {31'd0, m}, 32'd1);

    sel = 2'b11; j = 16'd3; k = 16'd4;
    applyStimulus();
    checkOutput("cmp3gt4.m", {31'd0, m}, 32'd0);

    // Reset mid-sequence with a multiply pending: everything clears.
    sel = 2'b11; j = 16'd9; k = 16'd1;
    applyStimulus();
    checkOutput("preReset.m", {31'd0, m}, 32'd1);

    rst = 1'b1; sel = 2'b01; x = 16'd7; y = 16'd9;
    applyStimulus();
    checkAll("midReset", 16'd0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0);

    // First operation after release lands one cycle later.
    rst = 1'b0; sel = 2'b00; a = 16'd1; b = 16'd2; cin = 1'b0;
    applyStimulus();
    checkAll("postReset", 16'd3, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_design.md
ALU_DESIGN -- requirements
Module: alu_design

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 sel  input  2  operation select.
REQ-005 a, b  input  16 each  adder operands (unsigned).
REQ-006 cin  input  1  adder carry-in.
REQ-007 x, y  input  16 each  multiplier operands (unsigned).
REQ-008 A, B  input  16 each  add/subtract operands (unsigned).
REQ-009 Op  input  1  add/subtract control: 0 = A+B, 1 = A-B.
REQ-010 j, k  input  16 each  comparator operands (unsigned).
REQ-011 y1  output  16  registered adder sum.
REQ-012 y2  output  32  registered product.
REQ-013 y3  output  16  registered add/subtract result.
REQ-014 cout  output  1  registered adder carry-out.
REQ-015 carry_out  output  1  registered add/subtract carry or no-borrow flag.
REQ-016 m  output  1  registered comparator result.

Function
REQ-017 All outputs SHALL be registered and update only on the rising edge of clk.
- Latency: exactly 1 cycle from the inputs sampled at an edge to the outputs.
REQ-018 sel=00: {cout, y1} SHALL be the 17-bit sum a + b + cin.
- Maximum value: 0xFFFF + 0xFFFF + 1 = 0x1FFFF.
REQ-019 sel=01: y2 SHALL be the full unsigned 32-bit product x * y.
- Computed in one cycle; no truncation.
REQ-020 sel=10, Op=0: {carry_out, y3} SHALL be the 17-bit sum A + B.
REQ-021 sel=10, Op=1: y3 SHALL be (A - B) mod 2^16, computed as A + ~B + 1.
- carry_out SHALL be 1 when A >= B (no borrow) and 0 when A < B.
REQ-022 sel=11: m SHALL be 1 when j > k (unsigned) and 0 otherwise.
- j == k gives m=0.
REQ-023 Only the outputs of the selected operation SHALL update.
- All other outputs hold their previous registered values.
REQ-024 cin SHALL be ignored unless sel=00, and Op SHALL be ignored unless sel=10.
REQ-025 Operand inputs not used by the selected operation SHALL have no effect on any output.
REQ-026 A change of sel between consecutive cycles SHALL take effect on the next edge, with no extra cycles or stalls.
REQ-027 There is no handshake: a new operation is accepted every cycle.

Reset
REQ-028 When rst=1 at a rising edge, all outputs SHALL be cleared to 0 regardless of sel and operands.
- Cleared: y1, y2, y3, cout, carry_out, m.
REQ-029 Reset SHALL take priority over any operation in the same cycle.
REQ-030 The first operation after rst deasserts SHALL appear one cycle after its inputs are sampled.
REQ-031 Reset asserted mid-sequence SHALL discard the pending result and leave all outputs at 0 until a new operation is sampled.

Verification
REQ-032 sel=00, a=10, b=20, cin=0 -> y1=30, cout=0; other outputs unchanged.
REQ-033 sel=00, a=0xFFFF, b=0x0001, cin=1 -> y1=0x0001, cout=1.
REQ-034 sel=01, x=25, y=11 -> y2=275 (0x00000113); sel=01, x=y=0xFFFF -> y2=0xFFFE0001.
REQ-035 sel=10, A=B=12, Op=1 -> y3=0, carry_out=1; then A=5, B=12, Op=1 -> y3=0xFFF9, carry_out=0; then A=12, B=12, Op=0 -> y3=24, carry_out=0.
REQ-036 sel=11, j=0xFF12, k=3 -> m=1; then j=3, k=3 -> m=0.
REQ-037 Reset scenario: drive nonzero results, then assert rst=1 for one edge with sel=01 active -> all outputs 0 at that edge; after release, sel=00, a=1, b=2 -> y1=3 one cycle later.
